// File: rtl/modn_clkdiv_multi.sv
// Multi-channel mod-N clock-enable divider with shadowed divisors.
// Each channel has a runtime divisor, toggle/pulse output and a terminal-count flag.
`timescale 1ns/1ps
module modn_clkdiv_multi #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 3
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic [NCH-1:0]     en,
    input  logic [NCH-1:0]     mode,
    input  logic [NCH*CNT_W-1:0] div_in,
    input  logic [NCH-1:0]     div_load,
    output logic [NCH-1:0]     y,
    output logic [NCH-1:0]     tc,
    output logic [NCH*CNT_W-1:0] count,
    output logic [NCH-1:0]     div_pend
);

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shadow;
        logic [CNT_W-1:0] din;
        logic             pend;
        logic             y_q;
        logic             tc_q;
        logic             ld;
        logic             wrap;
        logic             idle_apply;

        assign din  = div_in[k*CNT_W +: CNT_W];
        // A zero divisor is meaningless, so such a load is dropped.
        assign ld   = div_load[k] && (din != '0);
        assign wrap = en[k] && (cnt == div_act - 1'b1);
        // While disabled a pending divisor is applied at once, restarting the count.
        assign idle_apply = !en[k] && pend && !ld;

        // Counter, output waveform, and divisor shadow/apply logic.
        always_ff @(posedge i_clk or negedge reset) begin
            if (!reset) begin
                cnt        <= '0;
                div_act    <= DEF;
                div_shadow <= DEF;
                pend       <= 1'b0;
                y_q        <= 1'b0;
                tc_q       <= 1'b0;
            end else begin
                tc_q <= wrap;
                if (en[k]) begin
                    if (wrap) begin
                        cnt <= '0;
                        y_q <= mode[k] ? 1'b1 : ~y_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (mode[k]) y_q <= 1'b0;
                    end
                end else begin
                    if (mode[k]) y_q <= 1'b0;
                    if (idle_apply) cnt <= '0;
                end
                if (ld) begin
                    div_shadow <= din;
                    if (wrap) begin
                        div_act <= din;
                        pend    <= 1'b0;
                    end else begin
                        pend    <= 1'b1;
                    end
                end else if (pend && (wrap || !en[k])) begin
                    div_act <= div_shadow;
                    pend    <= 1'b0;
                end
            end
        end

        assign y[k]                     = y_q;
        assign tc[k]                    = tc_q;
        assign div_pend[k]              = pend;
        assign count[k*CNT_W +: CNT_W]  = cnt;
    end

endmodule

// File: tb/tb_modn_clkdiv_multi.sv
// Scoreboard bench for modn_clkdiv_multi (NCH=2, CNT_W=8, DEF_DIV=3).
// Each queued item carries the inputs for one edge and the expected outputs after it.
`timescale 1ns/1ps
module tb_modn_clkdiv_multi;

    localparam int W = 8;

    logic          i_clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    en = '0;
    logic [1:0]    mode = '0;
    logic [1:0]    div_load = '0;
    logic [15:0]   div_in = '0;
    logic [1:0]    y;
    logic [1:0]    tc;
    logic [15:0]   count;
    logic [1:0]    div_pend;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      nm;
        logic [1:0] en;
        logic [1:0] mode;
        logic [1:0] ld;
        logic [15:0] din;
        bit         m0;
        logic [10:0] e0;
        bit         m1;
        logic [10:0] e1;
    } item_t;

    item_t sb[$];
    item_t it;

    modn_clkdiv_multi #(.NCH(2), .CNT_W(W), .DEF_DIV(3)) dut (
        .i_clk(i_clk),
        .reset(reset),
        .en(en),
        .mode(mode),
        .div_in(div_in),
        .div_load(div_load),
        .y(y),
        .tc(tc),
        .count(count),
        .div_pend(div_pend)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [10:0] obs(int ch);
        return {tc[ch], y[ch], count[ch*W +: W], div_pend[ch]};
    endfunction

    function automatic logic [10:0] pk(bit t, bit yy, int c, bit p);
        logic [7:0] c8;
        c8 = 8'(c);
        return {t, yy, c8, p};
    endfunction

    function automatic void add(string nm, logic [1:0] e, logic [1:0] m,
                                logic [1:0] l, logic [15:0] d,
                                bit m0, logic [10:0] e0,
                                bit m1, logic [10:0] e1);
        item_t x;
        x = '{nm, e, m, l, d, m0, e0, m1, e1};
        sb.push_back(x);
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (obs(0) !== 11'h0) begin
            failures++;
            $display("FAIL reset ch0 got=%h want=%h", obs(0), 11'h0);
        end
        checks++;
        if (obs(1) !== 11'h0) begin
            failures++;
            $display("FAIL reset ch1 got=%h want=%h", obs(1), 11'h0);
        end
        reset = 1'b1;
    endtask

    task automatic test_toggle();
        for (int k = 1; k <= 12; k++)
            add("t1_toggle", 2'b01, 2'b00, 2'b00, 16'h0,
                1, pk(k % 3 == 0, (k / 3) % 2 == 1, k % 3, 0),
                1, pk(0, 0, 0, 0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m0) begin
                checks++;
                if (obs(0) !== it.e0) begin
                    failures++;
                    $display("FAIL %s ch0 got=%h want=%h", it.nm, obs(0), it.e0);
                end
            end
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
        div_load = '0;
    endtask

    task automatic test_pulse_load();
        add("t2_load", 2'b00, 2'b10, 2'b10, {8'd5, 8'd0},
            1, pk(0, 0, 0, 0), 1, pk(0, 0, 0, 1));
        add("t2_apply", 2'b00, 2'b10, 2'b00, 16'h0,
            1, pk(0, 0, 0, 0), 1, pk(0, 0, 0, 0));
        for (int k = 1; k <= 10; k++)
            add("t2_pulse", 2'b10, 2'b10, 2'b00, 16'h0,
                1, pk(0, 0, 0, 0),
                1, pk(k % 5 == 0, k % 5 == 0, k % 5, 0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m0) begin
                checks++;
                if (obs(0) !== it.e0) begin
                    failures++;
                    $display("FAIL %s ch0 got=%h want=%h", it.nm, obs(0), it.e0);
                end
            end
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
        div_load = '0;
    endtask

    task automatic test_hold();
        for (int k = 1; k <= 2; k++)
            add("t4_run", 2'b01, 2'b00, 2'b00, 16'h0,
                1, pk(0, 0, k, 0), 0, 11'h0);
        for (int k = 0; k < 7; k++)
            add("t4_hold", 2'b00, 2'b00, 2'b00, 16'h0,
                1, pk(0, 0, 2, 0), 0, 11'h0);
        add("t4_resume", 2'b01, 2'b00, 2'b00, 16'h0,
            1, pk(1, 1, 0, 0), 0, 11'h0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m0) begin
                checks++;
                if (obs(0) !== it.e0) begin
                    failures++;
                    $display("FAIL %s ch0 got=%h want=%h", it.nm, obs(0), it.e0);
                end
            end
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
        div_load = '0;
    endtask

    task automatic test_shadow();
        add("t3_pre", 2'b01, 2'b00, 2'b00, 16'h0,
            1, pk(0, 1, 1, 0), 0, 11'h0);
        add("t3_load", 2'b01, 2'b00, 2'b01, 16'h0004,
            1, pk(0, 1, 2, 1), 0, 11'h0);
        add("t3_wrap", 2'b01, 2'b00, 2'b00, 16'h0,
            1, pk(1, 0, 0, 0), 0, 11'h0);
        for (int j = 1; j <= 9; j++)
            add("t3_div4", 2'b01, 2'b00, 2'b00, 16'h0,
                1, pk(j % 4 == 0, (j / 4) % 2 == 1, j % 4, 0), 0, 11'h0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m0) begin
                checks++;
                if (obs(0) !== it.e0) begin
                    failures++;
                    $display("FAIL %s ch0 got=%h want=%h", it.nm, obs(0), it.e0);
                end
            end
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
        div_load = '0;
    endtask

    task automatic test_n1();
        add("t5_load1", 2'b01, 2'b00, 2'b01, 16'h0001,
            1, pk(0, 0, 2, 1), 0, 11'h0);
        add("t5_load0", 2'b01, 2'b00, 2'b01, 16'h0000,
            1, pk(0, 0, 3, 1), 0, 11'h0);
        add("t5_wrap", 2'b01, 2'b00, 2'b00, 16'h0,
            1, pk(1, 1, 0, 0), 0, 11'h0);
        for (int i = 1; i <= 6; i++)
            add("t5_n1", 2'b01, 2'b00, 2'b00, 16'h0,
                1, pk(1, (i + 1) % 2 == 1, 0, 0), 0, 11'h0);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m0) begin
                checks++;
                if (obs(0) !== it.e0) begin
                    failures++;
                    $display("FAIL %s ch0 got=%h want=%h", it.nm, obs(0), it.e0);
                end
            end
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
        div_load = '0;
    endtask

    task automatic test_async_reset();
        add("t6_run", 2'b11, 2'b10, 2'b00, 16'h0,
            0, 11'h0, 1, pk(0, 0, 1, 0));
        add("t6_load", 2'b11, 2'b10, 2'b10, {8'd7, 8'd0},
            0, 11'h0, 1, pk(0, 0, 2, 1));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
        div_load = '0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs(0) !== 11'h0) begin
            failures++;
            $display("FAIL t6_async ch0 got=%h want=%h", obs(0), 11'h0);
        end
        checks++;
        if (obs(1) !== 11'h0) begin
            failures++;
            $display("FAIL t6_async ch1 got=%h want=%h", obs(1), 11'h0);
        end
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (obs(0) !== 11'h0) begin
            failures++;
            $display("FAIL t6_held ch0 got=%h want=%h", obs(0), 11'h0);
        end
        checks++;
        if (obs(1) !== 11'h0) begin
            failures++;
            $display("FAIL t6_held ch1 got=%h want=%h", obs(1), 11'h0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 7; k++)
            add("t6_after", 2'b11, 2'b10, 2'b00, 16'h0,
                1, pk(k % 3 == 0, (k / 3) % 2 == 1, k % 3, 0),
                1, pk(k % 3 == 0, k % 3 == 0, k % 3, 0));
        while (sb.size() > 0) begin
            it = sb.pop_front();
            en = it.en; mode = it.mode; div_load = it.ld; div_in = it.din;
            step();
            if (it.m0) begin
                checks++;
                if (obs(0) !== it.e0) begin
                    failures++;
                    $display("FAIL %s ch0 got=%h want=%h", it.nm, obs(0), it.e0);
                end
            end
            if (it.m1) begin
                checks++;
                if (obs(1) !== it.e1) begin
                    failures++;
                    $display("FAIL %s ch1 got=%h want=%h", it.nm, obs(1), it.e1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_pulse_load();
        test_hold();
        test_shadow();
        test_n1();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
